// File: rtl/iterative_multiplier.sv
// Multi-cycle shift-add multiplier: WIDTH add/shift iterations on operand magnitudes,
// followed by one sign-fixup cycle. Start/busy/done handshake toward the control unit.
module iterative_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   upper;
  logic               neg;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc, result;
  logic               last;

  // The magnitude of the most-negative value still fits unsigned in WIDTH bits.
  always_comb begin
    a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
    sum    = {1'b0, upper} + {1'b0, mcand};
    acc    = {upper, mplier};
    result = neg ? -acc : acc;
    last   = (count == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // The carry of each partial sum shifts into the top of upper, so it is never dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      upper   <= '0;
      neg     <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            upper  <= '0;
            count  <= '0;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        RUN: begin
          if (mplier[0]) {upper, mplier} <= {sum, mplier[WIDTH-1:1]};
          else           {upper, mplier} <= {1'b0, upper, mplier[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        SIGN: begin
          product <= result;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
